// File: rtl/easy_fifo_wr_ctrl.sv
// Write-side control of the dual-clock FIFO: write pointer, read-pointer synchronizer, full/occupancy flags.
// Optional occupancy path (wr_count, almost_full) is built when EASY_FIFO_WR_ACOUNT_EN is defined.
module easy_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int N_SYNC       = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_async,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count
);

  localparam int AW = ADDR_WIDTH;
  localparam bit PARAMS_OK = (ADDR_WIDTH >= 2) && (N_SYNC >= 2) &&
                             (AFULL_THRESH >= 1) && (AFULL_THRESH <= 2**ADDR_WIDTH);

  if (!PARAMS_OK) begin : g_bad_params
    $error("easy_fifo_wr_ctrl: illegal parameter combination");
  end

  logic [AW:0] wr_bin_q, wr_bin_d;
  logic [AW:0] wr_gray_q, wr_gray_d;
  logic [AW:0] sync_q [N_SYNC];
  logic [AW:0] rd_gray_s;
  logic        full_q, full_d;
  logic        accept;

  // Reset also blocks the memory write in the cycle before full_q has been forced high.
  assign accept    = s_valid & ~full_q & ~rst;
  assign wr_bin_d  = wr_bin_q + {{AW{1'b0}}, accept};
  assign wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
  assign rd_gray_s = sync_q[N_SYNC-1];
  assign full_d    = (wr_gray_d == {~rd_gray_s[AW:AW-1], rd_gray_s[AW-2:0]});

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      full_q    <= 1'b1;
      for (int i = 0; i < N_SYNC; i++) sync_q[i] <= '0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      full_q    <= full_d;
      sync_q[0] <= rd_ptr_gray_async;
      for (int i = 1; i < N_SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_ready     = ~full_q;
  assign mem_we      = accept;
  assign mem_waddr   = wr_bin_q[AW-1:0];
  assign wr_ptr_gray = wr_gray_q;
  assign full        = full_q;

`ifdef EASY_FIFO_WR_ACOUNT_EN
  localparam logic [AW:0] AFULL_T = (AW+1)'(AFULL_THRESH);

  logic [AW:0] rd_bin_s;
  logic [AW:0] wr_count_q, wr_count_d;
  logic        afull_q, afull_d;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin_s = '0;
    for (int i = 0; i <= AW; i++) rd_bin_s = rd_bin_s ^ (rd_gray_s >> i);
  end

  assign wr_count_d = wr_bin_d - rd_bin_s;
  assign afull_d    = (wr_count_d >= AFULL_T);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
      afull_q    <= 1'b0;
    end else begin
      wr_count_q <= wr_count_d;
      afull_q    <= afull_d;
    end
  end

  assign wr_count    = wr_count_q;
  assign almost_full = afull_q;
`else
  assign wr_count    = '0;
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_easy_fifo_wr_ctrl.sv
// Directed bench for easy_fifo_wr_ctrl (ADDR_WIDTH=4, N_SYNC=2, AFULL_THRESH=12).
module tb_easy_fifo_wr_ctrl;

`ifdef EASY_FIFO_WR_ACOUNT_EN
  localparam bit ACNT = 1'b1;
`else
  localparam bit ACNT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [4:0] wr_ptr_gray;
  logic [4:0] rd_ptr_gray_async;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  easy_fifo_wr_ctrl #(.ADDR_WIDTH(4), .N_SYNC(2), .AFULL_THRESH(12)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .mem_we            (mem_we),
    .mem_waddr         (mem_waddr),
    .wr_ptr_gray       (wr_ptr_gray),
    .rd_ptr_gray_async (rd_ptr_gray_async),
    .full              (full),
    .almost_full       (almost_full),
    .wr_count          (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] cnt_exp(input int v);
    logic [4:0] r;
    r = ACNT ? 5'(v) : 5'd0;
    return r;
  endfunction

  initial begin
    int   exp_wr;
    int   rd_bin;
    int   full_seen;
    bit   wrap_seen;
    logic [4:0] prev_gray;

    rst = 1'b1;
    s_valid = 1'b0;
    rd_ptr_gray_async = 5'd0;

    // reset
    repeat (3) step();
    chk("rst_full", full, 1);
    chk("rst_ready", s_ready, 0);
    chk("rst_gray", wr_ptr_gray, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_afull", almost_full, 0);
    rst = 1'b0;
    step();
    chk("rel_full", full, 0);
    chk("rel_ready", s_ready, 1);

    // fill with static reader
    s_valid = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("fill_addr", mem_waddr, i);
      chk("fill_we", mem_we, 1);
      step();
      chk("fill_count", wr_count, cnt_exp(i + 1));
      if (i < 15) chk("fill_notfull", full, 0);
      if (i == 10) chk("afull_11", almost_full, 0);
      if (i == 11) chk("afull_12", almost_full, ACNT);
    end
    chk("full_set", full, 1);
    chk("full_ready", s_ready, 0);
    chk("full_gray", wr_ptr_gray, 5'b11000);
    chk("full_we", mem_we, 0);
    step();
    chk("w17_gray", wr_ptr_gray, 5'b11000);
    chk("w17_addr", mem_waddr, 0);
    chk("w17_full", full, 1);

    // drain visibility
    s_valid = 1'b0;
    rd_ptr_gray_async = 5'b00001;
    step();
    step();
    chk("drain_e2_full", full, 1);
    step();
    chk("drain_e3_full", full, 0);
    chk("drain_count", wr_count, cnt_exp(15));
    chk("drain_afull", almost_full, ACNT);

    // mid-operation reset
    rst = 1'b1;
    rd_ptr_gray_async = 5'd0;
    step();
    chk("mr0_full", full, 1);
    chk("mr0_gray", wr_ptr_gray, 0);
    rst = 1'b0;
    step();
    chk("mr0_rel_full", full, 0);
    s_valid = 1'b1;
    repeat (5) step();
    chk("mr_addr5", mem_waddr, 5);
    chk("mr_gray5", wr_ptr_gray, gray5(5'd5));
    rst = 1'b1;
    #1;
    chk("mr_we_in_rst", mem_we, 0);
    step();
    chk("mr_gray", wr_ptr_gray, 0);
    chk("mr_full", full, 1);
    chk("mr_addr", mem_waddr, 0);
    chk("mr_we_after", mem_we, 0);
    rst = 1'b0;
    step();
    chk("mr_rel_full", full, 0);
    chk("mr_first_addr", mem_waddr, 0);
    chk("mr_first_we", mem_we, 1);
    step();
    chk("mr_second_addr", mem_waddr, 1);

    // wrap with an advancing reader
    exp_wr = 1;
    rd_bin = 0;
    full_seen = 0;
    wrap_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("wrap_addr", mem_waddr, exp_wr & 15);
      prev_gray = wr_ptr_gray;
      step();
      exp_wr++;
      if (full) full_seen++;
      if (prev_gray == 5'b10000 && wr_ptr_gray == 5'b00000) wrap_seen = 1'b1;
      if (exp_wr - rd_bin > 4) begin
        rd_bin++;
        rd_ptr_gray_async = gray5(5'(rd_bin));
      end
    end
    chk("wrap_gray_seen", wrap_seen, 1);
    chk("wrap_full_seen", full_seen, 0);
    chk("wrap_gray_end", wr_ptr_gray, gray5(5'(exp_wr)));
    s_valid = 1'b0;
    repeat (4) step();
    chk("wrap_count", wr_count, cnt_exp((exp_wr - rd_bin) & 31));
    chk("wrap_addr_end", mem_waddr, exp_wr & 15);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
